// File: rtl/mmu_arb_pkg.sv
// Shared types and helpers for the MMU read-address arbiter.
package mmu_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mmu_ar_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [SEL_BITS-1:0] grant_idx
);

  logic [SEL_BITS-1:0] idx;
  logic                found;

  // NUM_REQ is a power of two, so the SEL_BITS-wide add wraps naturally.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_BITS'(i);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mmu_ar_arbiter.sv
// Arbitrates NUM_REQ AXI read-address channels onto one MMU port, tagging the
// ID with the requester index and routing R beats back by those tag bits.
module mmu_ar_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int SEL_BITS         = log2_ceil(NUM_REQ),
  parameter int AXI_REQ_ID_WIDTH = 3,
  parameter int AXI_ADDR_WIDTH   = 31,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int CNT_W            = log2_ceil(MAX_OUTSTANDING + 1)
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [NUM_REQ*AXI_REQ_ID_WIDTH-1:0]  req_arid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    req_araddr,
  input  logic [NUM_REQ*8-1:0]                 req_arlen,
  input  logic [NUM_REQ*3-1:0]                 req_arsize,
  input  logic [NUM_REQ*2-1:0]                 req_arburst,
  input  logic [NUM_REQ-1:0]                   req_arvalid,
  output logic [NUM_REQ-1:0]                   req_arready,
  output logic [AXI_REQ_ID_WIDTH-1:0]          req_rid,
  output logic [AXI_DATA_WIDTH-1:0]            req_rdata,
  output logic [1:0]                           req_rresp,
  output logic                                 req_rlast,
  output logic [NUM_REQ-1:0]                   req_rvalid,
  input  logic [NUM_REQ-1:0]                   req_rready,
  output logic [SEL_BITS+AXI_REQ_ID_WIDTH-1:0] mem_out_arid,
  output logic [AXI_ADDR_WIDTH-1:0]            mem_out_araddr,
  output logic [7:0]                           mem_out_arlen,
  output logic [2:0]                           mem_out_arsize,
  output logic [1:0]                           mem_out_arburst,
  output logic                                 mem_out_arvalid,
  input  logic                                 mem_out_arready,
  input  logic [SEL_BITS+AXI_REQ_ID_WIDTH-1:0] mem_out_rid,
  input  logic [AXI_DATA_WIDTH-1:0]            mem_out_rdata,
  input  logic [1:0]                           mem_out_rresp,
  input  logic                                 mem_out_rlast,
  input  logic                                 mem_out_rvalid,
  output logic                                 mem_out_rready,
  output arb_state_e                           dbg_state,
  output logic [SEL_BITS-1:0]                  dbg_rr_ptr,
  output logic [NUM_REQ*CNT_W-1:0]             dbg_count
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready
  // are both 1; valid never waits on ready, and a payload is held while valid.
  arb_state_e          state, state_next;
  logic [SEL_BITS-1:0] rr_ptr, grant_sel, arb_idx, rid_sel;
  logic [NUM_REQ-1:0]  eligible, arb_grant, inc, dec;
  logic [CNT_W-1:0]    count [NUM_REQ];
  logic                arb_valid;

  assign rid_sel   = mem_out_rid[SEL_BITS+AXI_REQ_ID_WIDTH-1 -: SEL_BITS];
  assign arb_valid = |eligible;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign eligible[g] = req_arvalid[g] && (count[g] < CNT_W'(MAX_OUTSTANDING));
    assign inc[g]      = req_arvalid[g] && req_arready[g];
    assign dec[g]      = mem_out_rvalid && mem_out_rready && mem_out_rlast
                         && (rid_sel == SEL_BITS'(g));
    assign req_rvalid[g] = mem_out_rvalid && (rid_sel == SEL_BITS'(g));
    assign dbg_count[g*CNT_W +: CNT_W] = count[g];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .SEL_BITS (SEL_BITS)
  ) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (arb_valid)       state_next = ST_SEND;
      ST_SEND: if (mem_out_arready) state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // arready is gated by areset so nothing is accepted while reset is held.
  always_comb begin
    req_arready     = '0;
    mem_out_arvalid = 1'b0;
    if (!areset && state == ST_IDLE) req_arready = arb_grant;
    if (state == ST_SEND)            mem_out_arvalid = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_sel       <= '0;
      rr_ptr          <= '0;
      mem_out_arid    <= '0;
      mem_out_araddr  <= '0;
      mem_out_arlen   <= '0;
      mem_out_arsize  <= '0;
      mem_out_arburst <= '0;
    end else if (state == ST_IDLE && arb_valid) begin
      grant_sel       <= arb_idx;
      mem_out_arid    <= {arb_idx, req_arid[arb_idx*AXI_REQ_ID_WIDTH +: AXI_REQ_ID_WIDTH]};
      mem_out_araddr  <= req_araddr[arb_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      mem_out_arlen   <= req_arlen[arb_idx*8 +: 8];
      mem_out_arsize  <= req_arsize[arb_idx*3 +: 3];
      mem_out_arburst <= req_arburst[arb_idx*2 +: 2];
    end else if (state == ST_SEND && mem_out_arready) begin
      rr_ptr <= grant_sel + SEL_BITS'(1);
    end
  end

  // Outstanding-burst counters; a stray last beat at zero is ignored.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i] && count[i] < CNT_W'(MAX_OUTSTANDING))
          count[i] <= count[i] + CNT_W'(1);
        else if (dec[i] && !inc[i] && count[i] != '0)
          count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  assign mem_out_rready = req_rready[rid_sel];
  assign req_rid        = mem_out_rid[AXI_REQ_ID_WIDTH-1:0];
  assign req_rdata      = mem_out_rdata;
  assign req_rresp      = mem_out_rresp;
  assign req_rlast      = mem_out_rlast;
  assign dbg_state      = state;
  assign dbg_rr_ptr     = rr_ptr;

endmodule

// File: tb/tb_mmu_ar_arbiter.sv
// Directed bench for mmu_ar_arbiter: vector table for grant order plus
// hand-written stall, outstanding-limit, R-routing and reset sequences.
module tb_mmu_ar_arbiter;
  import mmu_arb_pkg::*;

  localparam int NR  = 4;
  localparam int SB  = 2;
  localparam int IDW = 3;
  localparam int AW  = 31;
  localparam int DW  = 128;
  localparam int MO  = 8;
  localparam int CW  = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NR*IDW-1:0] req_arid;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*8-1:0]   req_arlen;
  logic [NR*3-1:0]   req_arsize;
  logic [NR*2-1:0]   req_arburst;
  logic [NR-1:0]     req_arvalid, req_arready;
  logic [IDW-1:0]    req_rid;
  logic [DW-1:0]     req_rdata;
  logic [1:0]        req_rresp;
  logic              req_rlast;
  logic [NR-1:0]     req_rvalid, req_rready;
  logic [SB+IDW-1:0] mem_out_arid;
  logic [AW-1:0]     mem_out_araddr;
  logic [7:0]        mem_out_arlen;
  logic [2:0]        mem_out_arsize;
  logic [1:0]        mem_out_arburst;
  logic              mem_out_arvalid, mem_out_arready;
  logic [SB+IDW-1:0] mem_out_rid;
  logic [DW-1:0]     mem_out_rdata;
  logic [1:0]        mem_out_rresp;
  logic              mem_out_rlast, mem_out_rvalid, mem_out_rready;
  arb_state_e        dbg_state;
  logic [SB-1:0]     dbg_rr_ptr;
  logic [NR*CW-1:0]  dbg_count;

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  mmu_ar_arbiter #(
    .NUM_REQ(NR), .AXI_REQ_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_arid(req_arid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rid(req_rid), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_rlast(req_rlast), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .mem_out_arid(mem_out_arid), .mem_out_araddr(mem_out_araddr),
    .mem_out_arlen(mem_out_arlen), .mem_out_arsize(mem_out_arsize),
    .mem_out_arburst(mem_out_arburst), .mem_out_arvalid(mem_out_arvalid),
    .mem_out_arready(mem_out_arready),
    .mem_out_rid(mem_out_rid), .mem_out_rdata(mem_out_rdata),
    .mem_out_rresp(mem_out_rresp), .mem_out_rlast(mem_out_rlast),
    .mem_out_rvalid(mem_out_rvalid), .mem_out_rready(mem_out_rready),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_count(dbg_count)
  );

  typedef struct {
    logic          rst_before;
    logic [NR-1:0] arvalid;
    logic          marready;
    logic [NR-1:0] exp_arready;
    logic          exp_arvalid;
    logic [4:0]    exp_arid;
    logic [1:0]    exp_ptr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return dbg_count[i*CW +: CW];
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    req_arvalid     = '0;
    mem_out_arready = 1'b0;
    mem_out_rvalid  = 1'b0;
    mem_out_rlast   = 1'b0;
    mem_out_rid     = '0;
    mem_out_rresp   = '0;
    mem_out_rdata   = '0;
    req_rready      = '0;
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    int hs;
    for (int i = 0; i < NR; i++) begin
      req_arid[i*IDW +: IDW]  = IDW'(i + 1);
      req_araddr[i*AW +: AW]  = AW'(32'h1000 * (i + 1));
      req_arlen[i*8 +: 8]     = 8'(i + 4);
      req_arsize[i*3 +: 3]    = 3'(i);
      req_arburst[i*2 +: 2]   = 2'b01;
    end

    vecs[0]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b0, 5'b00000, 2'd0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 5'b00001, 2'd0};
    vecs[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 5'b00001, 2'd1};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 5'b10011, 2'd1};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 5'b10011, 2'd3};
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 5'b00000, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 5'b00001, 2'd0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 5'b00001, 2'd1};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 5'b01010, 2'd1};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 5'b01010, 2'd2};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 5'b10011, 2'd2};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 5'b10011, 2'd3};
    vecs[12] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 5'b11100, 2'd3};
    vecs[13] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 5'b11100, 2'd0};
    vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 5'b00001, 2'd0};

    // Reset state, with every requester asking
    clear_inputs();
    areset      = 1'b1;
    req_arvalid = 4'b1111;
    #12;
    check("rst arready", req_arready, 4'b0000);
    check("rst arvalid", mem_out_arvalid, 1'b0);
    check("rst state", dbg_state, ST_IDLE);
    check("rst ptr", dbg_rr_ptr, 2'd0);
    check("rst count", dbg_count, 16'h0000);
    check("rst arid", mem_out_arid, 5'b00000);
    @(negedge aclk);
    do_reset();

    // Vector table: two-requester order and four-way rotation
    for (int k = 0; k < 15; k++) begin
      if (vecs[k].rst_before) do_reset();
      req_arvalid     = vecs[k].arvalid;
      mem_out_arready = vecs[k].marready;
      #1;
      check($sformatf("vec%0d arready", k), req_arready, vecs[k].exp_arready);
      check($sformatf("vec%0d arvalid", k), mem_out_arvalid, vecs[k].exp_arvalid);
      check($sformatf("vec%0d arid", k), mem_out_arid, vecs[k].exp_arid);
      check($sformatf("vec%0d ptr", k), dbg_rr_ptr, vecs[k].exp_ptr);
      @(negedge aclk);
    end
    check("rot count0", cnt(0), 4'd2);
    check("rot count3", cnt(3), 4'd1);

    // Stall in SEND for 5 cycles
    do_reset();
    req_arvalid = 4'b0010;
    #1;
    check("stall grant", req_arready, 4'b0010);
    @(negedge aclk);
    req_arvalid = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall%0d arvalid", c), mem_out_arvalid, 1'b1);
      check($sformatf("stall%0d arready", c), req_arready, 4'b0000);
      check($sformatf("stall%0d arid", c), mem_out_arid, 5'b01010);
      check($sformatf("stall%0d araddr", c), mem_out_araddr, 31'h2000);
      check($sformatf("stall%0d arlen", c), mem_out_arlen, 8'd5);
      @(negedge aclk);
    end
    mem_out_arready = 1'b1;
    @(negedge aclk);
    mem_out_arready = 1'b0;
    #1;
    check("stall release arvalid", mem_out_arvalid, 1'b0);
    check("stall next grant", req_arready, 4'b0100);
    @(negedge aclk);

    // Outstanding limit on requester 1
    do_reset();
    req_arvalid     = 4'b0010;
    mem_out_arready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_arready[1]) hs++;
      @(negedge aclk);
    end
    check("limit handshakes", hs, 8);
    check("limit count1", cnt(1), 4'd8);
    mem_out_rvalid = 1'b1;
    mem_out_rid    = 5'b01_010;
    mem_out_rlast  = 1'b1;
    req_rready     = 4'b0010;
    #1;
    check("limit blocked", req_arready, 4'b0000);
    check("limit rvalid", req_rvalid, 4'b0010);
    check("limit rready", mem_out_rready, 1'b1);
    @(negedge aclk);
    mem_out_rvalid = 1'b0;
    mem_out_rlast  = 1'b0;
    #1;
    check("limit count after rlast", cnt(1), 4'd7);
    check("limit reenabled", req_arready, 4'b0010);
    @(negedge aclk);

    // R routing and decrement at zero
    do_reset();
    mem_out_rvalid = 1'b1;
    mem_out_rid    = 5'b11_101;
    mem_out_rdata  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    mem_out_rresp  = 2'b10;
    mem_out_rlast  = 1'b1;
    req_rready     = 4'b0111;
    #1;
    check("route rvalid", req_rvalid, 4'b1000);
    check("route rid", req_rid, 3'b101);
    check("route rready low", mem_out_rready, 1'b0);
    check("route rdata", req_rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    check("route rresp", req_rresp, 2'b10);
    check("route rlast", req_rlast, 1'b1);
    req_rready = 4'b1000;
    #1;
    check("route rready high", mem_out_rready, 1'b1);
    @(negedge aclk);
    mem_out_rvalid = 1'b0;
    #1;
    check("route count3 at zero", cnt(3), 4'd0);
    @(negedge aclk);

    // Reset while in SEND with count0 = 3
    do_reset();
    req_arvalid     = 4'b0001;
    mem_out_arready = 1'b1;
    repeat (4) @(negedge aclk);
    mem_out_arready = 1'b0;
    @(negedge aclk);
    req_arvalid = 4'b0000;
    #1;
    check("rsend state", dbg_state, ST_SEND);
    check("rsend arvalid", mem_out_arvalid, 1'b1);
    check("rsend count0", cnt(0), 4'd3);
    #2;
    areset = 1'b1;
    #1;
    check("rsend arvalid drop", mem_out_arvalid, 1'b0);
    check("rsend count0 clear", cnt(0), 4'd0);
    check("rsend state idle", dbg_state, ST_IDLE);
    check("rsend araddr clear", mem_out_araddr, 31'h0);
    @(negedge aclk);
    areset          = 1'b0;
    mem_out_arready = 1'b1;
    req_arvalid     = 4'b0011;
    #1;
    check("rsend no replay", mem_out_arvalid, 1'b0);
    check("rsend first grant", req_arready, 4'b0001);
    @(negedge aclk);
    clear_inputs();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_ar_arbiter.md
MMU_AR_ARBITER -- requirements
Module: mmu_ar_arbiter

Interface
REQ-001 NUM_REQ, 4, number of requesters; power of two, 2..16.
REQ-002 SEL_BITS, log2(NUM_REQ), requester-index bits prepended to ID.
REQ-003 AXI_REQ_ID_WIDTH, 3, per-requester ID width.
REQ-004 AXI_ADDR_WIDTH, 31, address width, passed through unchanged.
REQ-005 AXI_DATA_WIDTH, 128, read data width.
REQ-006 MAX_OUTSTANDING, 8, per-requester limit on open read bursts, 1..255.
REQ-007 aclk  in  1  the block's one clock; all state changes on its rising edge.
REQ-008 areset  in  1  reset, asynchronous, active-high.
REQ-009 req_arid/araddr/arlen/arsize/arburst  in  NUM_REQ x field width, flattened  per-requester AR payload.
REQ-010 req_arvalid  in  NUM_REQ; req_arready  out  NUM_REQ  per-requester AR handshake.
REQ-011 req_rid  out  AXI_REQ_ID_WIDTH; req_rdata  out  AXI_DATA_WIDTH; req_rresp  out  2; req_rlast  out  1  shared R payload.
REQ-012 req_rvalid  out  NUM_REQ; req_rready  in  NUM_REQ  per-requester R handshake.
REQ-013 mem_out_arid  out  SEL_BITS+AXI_REQ_ID_WIDTH; mem_out_araddr/arlen/arsize/arburst  out  field width; mem_out_arvalid  out  1; mem_out_arready  in  1  AR master toward the MMU.
REQ-014 mem_out_rid/rdata/rresp/rlast/rvalid  in  matching widths; mem_out_rready  out  1  R slave from the MMU.

Function
REQ-015 The block SHALL run a two-state FSM: IDLE, SEND.
REQ-016 In IDLE, eligible requester i = req_arvalid[i] AND count[i] < MAX_OUTSTANDING.
REQ-017 In IDLE with at least one eligible requester, the block SHALL grant the first eligible index at or after rr_ptr (wrapping NUM_REQ-1 -> 0), assert req_arready[grant] that cycle, register the payload with mem_out_arid = {grant, req_arid[grant]}, and enter SEND.
REQ-018 In IDLE, all req_arready bits other than the granted one SHALL be 0; with no eligible requester, all bits SHALL be 0 and the FSM stays in IDLE.
REQ-019 In SEND, mem_out_arvalid SHALL be 1, the registered payload SHALL remain stable, and all req_arready bits SHALL be 0.
REQ-020 In SEND, on mem_out_arready = 1, the FSM SHALL return to IDLE and rr_ptr SHALL become grant+1 mod NUM_REQ.
REQ-021 Maximum AR throughput SHALL be one request per two cycles; AR latency from requester handshake to mem_out_arvalid is 1 cycle.
REQ-022 count[i] SHALL increment on a requester-i AR handshake.
REQ-023 count[i] SHALL decrement on mem_out_rvalid AND mem_out_rready AND mem_out_rlast with rid[MSBs] = i.
REQ-024 Simultaneous increment and decrement on the same i SHALL leave count[i] unchanged.
REQ-025 count[i] SHALL never exceed MAX_OUTSTANDING; a decrement at 0 is a protocol error and SHALL hold the count at 0.
REQ-026 R routing SHALL be combinational with zero latency:
- req_rvalid[i] = mem_out_rvalid AND (rid MSBs = i);
- mem_out_rready = req_rready[rid MSBs];
- req_rid = rid low AXI_REQ_ID_WIDTH bits;
- rdata, rresp and rlast pass through unchanged.

Reset
REQ-027 While areset is high, regardless of clock:
- FSM = IDLE, rr_ptr = 0, all counts = 0;
- mem_out_arvalid = 0, req_arready = 0, registered payload = 0.
REQ-028 Reset asserted during SEND SHALL drop the pending request; no replay after release.
REQ-029 The first grant is possible on the first rising aclk edge after areset deasserts.

Structure
REQ-030 Package mmu_arb_pkg SHALL hold the FSM state enum and the log2 helper constant function.
REQ-031 Round-robin selection SHALL be a sub-module, rr_arbiter: inputs request vector and pointer; outputs one-hot grant and index.

Verification
REQ-032 Requesters 0 and 2 valid in the same cycle, rr_ptr = 0, arready held 1: grants 0 then 2; mem_out_arid MSBs = 0 then 2; rr_ptr = 3.
REQ-033 All four requesters continuously valid: grant order 0,1,2,3,0; one mem_out_arvalid pulse every 2 cycles.
REQ-034 Requester 1 issues 8 ARs with no R responses: the 9th request is not granted (req_arready[1] stays 0); one rlast beat with rid MSBs = 1 re-enables it the next cycle.
REQ-035 mem_out_arready held 0 for 5 cycles in SEND: payload stable, arvalid stays 1, no other requester receives arready.
REQ-036 R beat with rid = {2'b11, 3'b101}, req_rready[3] = 0: req_rvalid = 4'b1000, req_rid = 3'b101, mem_out_rready = 0.
REQ-037 areset pulsed while in SEND with count[0] = 3: mem_out_arvalid drops immediately, count[0] = 0, next grant starts from requester 0.
